// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive sides:
// transmitter state encoding and parity-type codes.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period timer for the UART transmitter: latches the prescale at frame
// start and pulses o_bit_end on the last clock of every serial bit.
module uart_tx_baud_cnt #(
    parameter int PRSC_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_enable,
    input  logic [PRSC_WIDTH-1:0] i_prescale,
    output logic                  o_bit_end
);

    logic [PRSC_WIDTH-1:0] r_prescale;
    logic [PRSC_WIDTH-1:0] r_cnt;
    logic [PRSC_WIDTH-1:0] w_last;

    assign w_last    = r_prescale - PRSC_WIDTH'(1);
    assign o_bit_end = i_enable && (r_cnt == w_last);

    // Prescales of 0 or 1 cannot form a full bit period, so they run at 2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prescale <= PRSC_WIDTH'(2);
            r_cnt      <= '0;
        end else if (i_load) begin
            r_prescale <= (i_prescale < PRSC_WIDTH'(2)) ? PRSC_WIDTH'(2) : i_prescale;
            r_cnt      <= '0;
        end else if (o_bit_end || !i_enable) begin
            r_cnt      <= '0;
        end else begin
            r_cnt      <= r_cnt + PRSC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: one byte per valid/busy handshake, sent LSB-first as
// start, data, optional parity and one stop bit, each i_prescale clocks long.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MAX_PRESCALE = 32,
    parameter int PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PRSC_WIDTH-1:0] i_prescale,
    input  logic                  i_data_valid,
    input  logic [WIDTH-1:0]      i_parallel_data,
    input  logic                  i_parity_enable,
    input  logic                  i_parity_type,
    output logic                  o_serial_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        r_state, w_state_next;
    logic [WIDTH-1:0] r_data, w_data_next;
    logic [IDX_W-1:0] r_bit_idx, w_bit_idx_next;
    logic             r_par_en, w_par_en_next;
    logic             r_par_type, w_par_type_next;
    logic             r_serial, w_serial_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    logic             w_accept;
    logic             w_bit_end;
    logic             w_parity;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_last_bit;

    assign w_accept   = (r_state == TX_IDLE) && i_data_valid;
    assign w_idx_inc  = r_bit_idx + IDX_W'(1);
    assign w_last_bit = (r_bit_idx == IDX_W'(WIDTH - 1));

    always_comb begin
        w_parity = ^r_data;
        case (r_par_type)
            PAR_EVEN: w_parity = ^r_data;
            PAR_ODD:  w_parity = ~(^r_data);
            default:  w_parity = ^r_data;
        endcase
    end

    uart_tx_baud_cnt #(
        .PRSC_WIDTH (PRSC_WIDTH)
    ) u_baud_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_enable   (r_busy),
        .i_prescale (i_prescale),
        .o_bit_end  (w_bit_end)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= TX_IDLE;
            r_data     <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_bit_idx  <= w_bit_idx_next;
            r_par_en   <= w_par_en_next;
            r_par_type <= w_par_type_next;
            r_serial   <= w_serial_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // The line value for the next bit is registered on the same edge the
    // state advances, so o_serial_data changes exactly at bit boundaries.
    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_bit_idx_next  = r_bit_idx;
        w_par_en_next   = r_par_en;
        w_par_type_next = r_par_type;
        w_serial_next   = r_serial;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_serial_next = 1'b1;
                w_busy_next   = 1'b0;
                if (i_data_valid) begin
                    w_state_next    = TX_START;
                    w_data_next     = i_parallel_data;
                    w_par_en_next   = i_parity_enable;
                    w_par_type_next = i_parity_type;
                    w_bit_idx_next  = '0;
                    w_serial_next   = 1'b0;
                    w_busy_next     = 1'b1;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state_next   = TX_DATA;
                    w_bit_idx_next = '0;
                    w_serial_next  = r_data[0];
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    if (!w_last_bit) begin
                        w_bit_idx_next = w_idx_inc;
                        w_serial_next  = r_data[w_idx_inc];
                    end else if (r_par_en) begin
                        w_state_next  = TX_PARITY;
                        w_serial_next = w_parity;
                    end else begin
                        w_state_next  = TX_STOP;
                        w_serial_next = 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_bit_end) begin
                    w_state_next  = TX_STOP;
                    w_serial_next = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    w_state_next  = TX_IDLE;
                    w_serial_next = 1'b1;
                    w_busy_next   = 1'b0;
                    w_done_next   = 1'b1;
                end
            end
            default: begin
                w_state_next  = TX_IDLE;
                w_serial_next = 1'b1;
                w_busy_next   = 1'b0;
            end
        endcase
    end

    assign o_serial_data = r_serial;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: frames are queued as issued and a monitor
// rebuilds each expected cycle-by-cycle line waveform when o_done appears.
module tb_uart_tx_top;

    localparam int WIDTH        = 8;
    localparam int MAX_PRESCALE = 32;
    localparam int PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic [PRSC_WIDTH-1:0] i_prescale = '0;
    logic                  i_data_valid = 1'b0;
    logic [WIDTH-1:0]      i_parallel_data = '0;
    logic                  i_parity_enable = 1'b0;
    logic                  i_parity_type = 1'b0;
    logic                  o_serial_data;
    logic                  o_busy;
    logic                  o_done;

    uart_tx_top #(
        .WIDTH        (WIDTH),
        .MAX_PRESCALE (MAX_PRESCALE),
        .PRSC_WIDTH   (PRSC_WIDTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_prescale      (i_prescale),
        .i_data_valid    (i_data_valid),
        .i_parallel_data (i_parallel_data),
        .i_parity_enable (i_parity_enable),
        .i_parity_type   (i_parity_type),
        .o_serial_data   (o_serial_data),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [7:0]       p;
        logic             pen;
        logic             pt;
    } frame_t;

    frame_t sb_q[$];
    bit     cap[$];
    int     checks = 0;
    int     errors = 0;

    function automatic int eff_p(frame_t f);
        return (f.p < 2) ? 2 : int'(f.p);
    endfunction

    function automatic int exp_len(frame_t f);
        return (f.pen ? WIDTH + 3 : WIDTH + 2) * eff_p(f);
    endfunction

    // Line value during cycle c of the frame (cycle 0 = cycle after accept).
    function automatic bit exp_bit(frame_t f, int c);
        int n;
        n = c / eff_p(f);
        if (n == 0) return 1'b0;
        if (n <= WIDTH) return f.d[n-1];
        if (n == WIDTH + 1 && f.pen) return bit'(($countones(f.d) % 2) == 1) ^ f.pt;
        return 1'b1;
    endfunction

    // Monitor: records the line while busy and scores the frame at o_done.
    initial begin
        frame_t f;
        int     first;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                cap.delete();
            end else begin
                if (o_busy) cap.push_back(o_serial_data);
                if (o_done) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_pulse: o_done=1 with no frame outstanding (captured %0d cycles)", cap.size());
                    end else begin
                        f = sb_q.pop_front();
                        if (cap.size() != exp_len(f)) begin
                            errors++;
                            $display("FAIL frame_len: data=%02h p=%0d par=%0d/%0d busy cycles=%0d expected=%0d",
                                     f.d, f.p, f.pen, f.pt, cap.size(), exp_len(f));
                        end
                        checks++;
                        first = -1;
                        for (int i = 0; i < cap.size() && i < exp_len(f); i++) begin
                            if (first < 0 && cap[i] !== exp_bit(f, i)) first = i;
                        end
                        if (first >= 0) begin
                            errors++;
                            $display("FAIL frame_bits: data=%02h p=%0d par=%0d/%0d cycle %0d line=%0b expected=%0b",
                                     f.d, f.p, f.pen, f.pt, first, cap[first], exp_bit(f, first));
                        end else begin
                            $display("frame data=%02h p=%0d par=%0d/%0d cycles=%0d", f.d, f.p, f.pen, f.pt, cap.size());
                        end
                    end
                    cap.delete();
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] d, input int p, input bit pen, input bit pt);
        frame_t f;
        f.d = d; f.p = 8'(p); f.pen = pen; f.pt = pt;
        i_parallel_data = d;
        i_prescale      = PRSC_WIDTH'(p);
        i_parity_enable = pen;
        i_parity_type   = pt;
        i_data_valid    = 1'b1;
        sb_q.push_back(f);
    endtask

    // Accept edge, then scramble every input (valid kept high) until o_done.
    task automatic finish_frame();
        bit seen;
        @(posedge i_clk);
        #1;
        checks++;
        if (!(o_busy === 1'b1 && o_serial_data === 1'b0)) begin
            errors++;
            $display("FAIL accept: busy=%b line=%b expected busy=1 line=0", o_busy, o_serial_data);
        end
        i_parallel_data = WIDTH'($urandom);
        i_prescale      = PRSC_WIDTH'($urandom_range(0, 63));
        i_parity_enable = 1'($urandom);
        i_parity_type   = 1'($urandom);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no o_done within 2000 cycles");
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] p;
        logic       pen;
        logic       pt;
    } stim_t;

    stim_t dir_tab[9];

    initial begin
        dir_tab[0] = '{8'hA5,  8, 1'b0, 1'b0};
        dir_tab[1] = '{8'h07, 16, 1'b1, 1'b0};
        dir_tab[2] = '{8'h07, 16, 1'b1, 1'b1};
        dir_tab[3] = '{8'hA5, 16, 1'b1, 1'b1};
        dir_tab[4] = '{8'h3C,  8, 1'b0, 1'b0};
        dir_tab[5] = '{8'hC3,  8, 1'b1, 1'b0};
        dir_tab[6] = '{8'h5E,  0, 1'b0, 1'b0};
        dir_tab[7] = '{8'h81,  1, 1'b1, 1'b1};
        dir_tab[8] = '{8'hF0, 32, 1'b0, 1'b0};

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (!(o_serial_data === 1'b1 && o_busy === 1'b0 && o_done === 1'b0)) begin
            errors++;
            $display("FAIL reset_state: line=%b busy=%b done=%b expected 1/0/0", o_serial_data, o_busy, o_done);
        end

        // Directed frames, back to back with valid held high throughout.
        for (int i = 0; i < 9; i++) begin
            issue(dir_tab[i].d, int'(dir_tab[i].p), dir_tab[i].pen, dir_tab[i].pt);
            finish_frame();
        end
        i_data_valid = 1'b0;
        repeat (4) @(negedge i_clk);

        // Reset during data bit 3 of a prescale-8 frame.
        issue(8'h96, 8, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
        repeat (34) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checks++;
        if (!(o_serial_data === 1'b1 && o_busy === 1'b0 && o_done === 1'b0)) begin
            errors++;
            $display("FAIL async_reset: line=%b busy=%b done=%b expected 1/0/0", o_serial_data, o_busy, o_done);
        end
        sb_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        issue(8'h5A, 8, 1'b0, 1'b0);
        finish_frame();
        i_data_valid = 1'b0;
        repeat (3) @(negedge i_clk);

        // Randomized frames, sometimes back to back, sometimes with idle gaps.
        for (int i = 0; i < 24; i++) begin
            issue(WIDTH'($urandom), int'($urandom_range(0, MAX_PRESCALE)), 1'($urandom), 1'($urandom));
            finish_frame();
            if ($urandom_range(0, 1) == 1) begin
                i_data_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge i_clk);
            end
        end
        i_data_valid = 1'b0;
        repeat (6) @(negedge i_clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", sb_q.size());
        end
        checks++;
        if (!(o_serial_data === 1'b1 && o_busy === 1'b0)) begin
            errors++;
            $display("FAIL final_idle: line=%b busy=%b expected 1/0", o_serial_data, o_busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

UART transmitter: accepts one parallel byte per valid/busy handshake and serializes it LSB-first as start bit, data bits, optional parity bit and one stop bit. Each bit lasts `i_prescale` clock cycles, so `i_prescale` and the parity settings must match the receiver's. The block is the transmit side of the UART peripheral, driving the serial line toward the external receiver. All timing is derived internally from the single system clock; no separate baud clock is needed.

## Interface
- `WIDTH`, 8, data bits per frame.
- `MAX_PRESCALE`, 32, largest supported clocks-per-bit.
- `PRSC_WIDTH`, `$clog2(MAX_PRESCALE)+1`, width of the prescale input.
- `i_clk` input 1: system clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_prescale` input `PRSC_WIDTH`: clock cycles per serial bit.
- `i_data_valid` input 1: request to send `i_parallel_data`.
- `i_parallel_data` input `WIDTH`: byte to transmit.
- `i_parity_enable` input 1: 1 inserts a parity bit.
- `i_parity_type` input 1: 0 = even, 1 = odd.
- `o_serial_data` output 1: serial line, registered, idles high.
- `o_busy` output 1: registered; high while a frame is in progress.
- `o_done` output 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: state is IDLE and `i_data_valid`=1 at a rising edge.
  - On accept, latch data, prescale, parity enable and parity type.
  - Go to START.
  - Inputs are ignored while `o_busy`=1; changing them mid-frame has no effect.
- Line value per state:
  - START: 0.
  - DATA: `data[bit_idx]`, with `bit_idx` running 0..`WIDTH`-1.
  - PARITY: XOR of latched data, further XOR'd with the latched parity type.
  - STOP: 1.
  - IDLE: 1.
- Bit timer counts 0..P-1, where P is the latched prescale.
  - The state advances when the count reaches P-1; the count then wraps to 0.
  - A latched prescale below 2 is treated as 2.
- Transitions:
  - START → DATA.
  - DATA → DATA while `bit_idx` < `WIDTH`-1, else PARITY if parity is enabled, else STOP.
  - PARITY → STOP.
  - STOP → IDLE, with `o_done`=1 for that one cycle.
- Reset, including mid-frame: immediately IDLE, `o_serial_data`=1, `o_busy`=0, `o_done`=0, counters cleared.

## Timing
- Accept at edge k: from edge k, `o_serial_data`=0 and `o_busy`=1.
- Frame length F = `WIDTH`+2, or `WIDTH`+3 with parity. Bit n of the frame is driven from edge k+n·P.
- At edge k+F·P: line stays 1, `o_busy` falls, and `o_done` is high for the cycle that follows.
- Earliest next accept is edge k+F·P+1, so consecutive frames are separated by at least one extra idle-high clock.
- `o_busy` is registered. A valid held high across frames is accepted exactly once per frame.
- The latched bit width is 1 + `WIDTH` + parity + 1; no variable stop length.

## Structure
- Shared package `uart_pkg`:
  - TX state enum encoding.
  - Parity-type constants `PAR_EVEN`=0 and `PAR_ODD`=1, shared with the receive side.
- Sub-module `uart_tx_baud_cnt`:
  - Holds the bit-period counter (enable, latched prescale, clamp to 2).
  - Produces a `bit_end` pulse.
- FSM, shift/index logic and parity generation live in the top.

## Test plan
- Prescale 8, parity off, send 0xA5:
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - `o_busy` high for exactly 80 cycles.
  - `o_done` pulses once at cycle 80.
- Prescale 16, parity even, 0x07:
  - Parity bit = 1.
  - Frame 11 bits = 176 cycles.
- Same frame with odd parity:
  - Parity bit = 0.
  - Repeat with 0xA5 odd: parity bit = 1.
- Valid held high, two bytes 0x3C then 0xC3:
  - Second start bit begins exactly one idle-high cycle after the first frame's `o_done` cycle.
  - Change data, parity and prescale mid-frame: first frame is unaffected.
- Prescale 0 and prescale 1:
  - Each bit lasts 2 cycles.
  - Prescale 32: each bit lasts 32 cycles.
- Assert `i_rst` during DATA bit 3:
  - Line returns to 1 asynchronously, `o_busy`=0.
  - After release, a new 0x5A frame transmits correctly from its start bit.
